// File: rtl/conv9_pkg.sv
// Shared definitions for the conv9 MAC datapath and its sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: window geometry, weight width, the packed weight-row type used
// between the weight ROM and the convolution engine, and the sequencer state.
package conv9_pkg;

  localparam int CONV9_ROWS = 9;
  localparam int WEIGHT_W   = 18;

  typedef logic signed [CONV9_ROWS-1:0][WEIGHT_W-1:0] weight_row_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/conv9_filter_sequencer.sv
// Walks the weight ROM over every active filter for one accepted 9x9 window.
// Latency: accept to first valid weight row is 2 cycles; window period is 9*nf+2.
// Backpressure: ready_out is high only in IDLE; window_valid_in is ignored while busy.
//
// Ports:
//   clk_in, rst_in             clock, asynchronous active-high reset
//   window_valid_in/ready_out  window handshake with the rolling buffer
//   hcount_in/vcount_in        window coordinates, latched at accept
//   active_filters_in          number of filters to run, sampled at accept
//   rom_addr_out/rom_data_in   weight ROM port (registered ROM, 1-cycle read)
//   weight_row_out, row_num_out, filter_out, row_valid_out
//                              one weight row per cycle to the MAC engine
//   window_done_out            pulses with the final row of the final filter
//   hcount_out/vcount_out      coordinates of the window being processed
module conv9_filter_sequencer
  import conv9_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int FW          = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  parameter int AW          = $clog2(NUM_FILTERS * CONV9_ROWS)
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  window_valid_in,
  input  logic [4:0]                            hcount_in,
  input  logic [4:0]                            vcount_in,
  input  logic [FW:0]                           active_filters_in,
  output logic                                  ready_out,
  output logic [AW-1:0]                         rom_addr_out,
  input  logic signed [CONV9_ROWS*WEIGHT_W-1:0] rom_data_in,
  output logic signed [CONV9_ROWS*WEIGHT_W-1:0] weight_row_out,
  output logic [3:0]                            row_num_out,
  output logic [FW-1:0]                         filter_out,
  output logic                                  row_valid_out,
  output logic                                  window_done_out,
  output logic [4:0]                            hcount_out,
  output logic [4:0]                            vcount_out
);

  localparam logic [3:0]  ROW_LAST = 4'(CONV9_ROWS - 1);
  localparam logic [FW:0] NF_ONE   = (FW + 1)'(1);
  localparam logic [FW:0] NF_MAX   = (FW + 1)'(NUM_FILTERS);
  localparam logic [FW-1:0] FILT_ONE = FW'(1);

  seq_state_t    state_q;
  seq_state_t    state_d;
  logic [3:0]    row_q;
  logic [FW-1:0] filt_q;
  logic [FW:0]   nf_q;
  logic [FW:0]   nf_clamped;
  logic [FW:0]   nf_last;
  logic          accept;
  logic          issuing;
  logic          issue_last;

  // Out-of-range filter counts are folded into 1..NUM_FILTERS so a bad
  // request still produces a well-formed window with exactly one done pulse.
  always_comb begin
    nf_clamped = active_filters_in;
    if (active_filters_in == '0) begin
      nf_clamped = NF_ONE;
    end else if (active_filters_in > NF_MAX) begin
      nf_clamped = NF_MAX;
    end
  end

  assign nf_last    = nf_q - NF_ONE;
  assign issuing    = (state_q == SEQ_ISSUE);
  assign issue_last = issuing && (row_q == ROW_LAST) && ({1'b0, filt_q} == nf_last);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake.
  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    accept    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        ready_out = 1'b1;
        if (window_valid_in) begin
          accept  = 1'b1;
          state_d = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (issue_last) begin
          state_d = SEQ_DRAIN;
        end
      end
      // The last ROM read is still in flight; give it one cycle to land.
      SEQ_DRAIN: state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  // Row/filter walk and per-window latched context.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_q      <= '0;
      filt_q     <= '0;
      nf_q       <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else if (accept) begin
      row_q      <= '0;
      filt_q     <= '0;
      nf_q       <= nf_clamped;
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
    end else if (issuing) begin
      if (row_q == ROW_LAST) begin
        row_q <= '0;
        // Hold the filter index on the final row so it never wraps past nf.
        if (!issue_last) begin
          filt_q <= filt_q + FILT_ONE;
        end
      end else begin
        row_q <= row_q + 4'd1;
      end
    end
  end

  assign rom_addr_out = issuing ? (AW'(filt_q) * AW'(CONV9_ROWS) + AW'(row_q)) : '0;

  // One register stage so row tags line up with the registered ROM output.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_valid_out <= 1'b0;
      row_num_out   <= '0;
      filter_out    <= '0;
    end else begin
      row_valid_out <= issuing;
      row_num_out   <= issuing ? row_q : 4'd0;
      filter_out    <= issuing ? filt_q : '0;
    end
  end

  assign weight_row_out  = row_valid_out ? rom_data_in : '0;
  assign window_done_out = row_valid_out && (row_num_out == ROW_LAST) &&
                           ({1'b0, filter_out} == nf_last);

endmodule

// File: tb/tb_conv9_filter_sequencer.sv
// Scoreboard bench for conv9_filter_sequencer with NUM_FILTERS=4.
// ROM row k holds element j = k*0x100 + j.
module tb_conv9_filter_sequencer;
  import conv9_pkg::*;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int AW = 6;

  logic                 clk;
  logic                 rst_in;
  logic                 window_valid_in;
  logic [4:0]           hcount_in;
  logic [4:0]           vcount_in;
  logic [FW:0]          active_filters_in;
  logic                 ready_out;
  logic [AW-1:0]        rom_addr_out;
  logic signed [161:0]  rom_data_in;
  logic signed [161:0]  weight_row_out;
  logic [3:0]           row_num_out;
  logic [FW-1:0]        filter_out;
  logic                 row_valid_out;
  logic                 window_done_out;
  logic [4:0]           hcount_out;
  logic [4:0]           vcount_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [161:0]  data;
    logic [AW-1:0] addr;
    logic [3:0]    row;
    logic [FW-1:0] filt;
    logic          done;
    logic [4:0]    h;
    logic [4:0]    v;
  } exp_t;

  exp_t sb[$];
  logic [161:0] rom_mem [0:35];

  conv9_filter_sequencer #(.NUM_FILTERS(NF)) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .window_valid_in   (window_valid_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .active_filters_in (active_filters_in),
    .ready_out         (ready_out),
    .rom_addr_out      (rom_addr_out),
    .rom_data_in       (rom_data_in),
    .weight_row_out    (weight_row_out),
    .row_num_out       (row_num_out),
    .filter_out        (filter_out),
    .row_valid_out     (row_valid_out),
    .window_done_out   (window_done_out),
    .hcount_out        (hcount_out),
    .vcount_out        (vcount_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [161:0] rom_word(input int k);
    weight_row_t w;
    for (int j = 0; j < 9; j++) w[j] = 18'(k * 256 + j);
    return w;
  endfunction

  initial begin
    for (int k = 0; k < 36; k++) rom_mem[k] = rom_word(k);
  end

  // Registered ROM, one-cycle read latency.
  always @(posedge clk) begin
    rom_data_in <= (rom_addr_out < 6'd36) ? rom_mem[rom_addr_out] : '0;
  end

  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_nf(input int act);
    if (act == 0) return 1;
    if (act > NF) return NF;
    return act;
  endfunction

  task automatic push_window(input int h, input int v, input int nf);
    exp_t e;
    for (int f = 0; f < nf; f++) begin
      for (int r = 0; r < 9; r++) begin
        e.addr = AW'(f * 9 + r);
        e.data = rom_word(f * 9 + r);
        e.row  = 4'(r);
        e.filt = FW'(f);
        e.done = (r == 8) && (f == nf - 1);
        e.h    = 5'(h);
        e.v    = 5'(v);
        sb.push_back(e);
      end
    end
  endtask

  // Returns at the negedge of cycle 1 (accept edge is edge 0).
  task automatic accept_window(input int h, input int v, input int act);
    int t;
    t = 0;
    while (!ready_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_accept", ready_out, 1);
    hcount_in         = 5'(h);
    vcount_in         = 5'(v);
    active_filters_in = (FW + 1)'(act);
    window_valid_in   = 1'b1;
    push_window(h, v, clamp_nf(act));
    @(negedge clk);
    window_valid_in = 1'b0;
  endtask

  task automatic finish_window(input int nf, input int c0);
    int c;
    c = c0;
    while (!ready_out && c < 9 * nf + 10) begin
      if (c == 1) begin
        check("addr_cycle1", rom_addr_out, 0);
        check("valid_cycle1", row_valid_out, 0);
      end
      if (c == 2) check("valid_cycle2", row_valid_out, 1);
      if (c == 9 * nf + 1) check("done_cycle", window_done_out, 1);
      @(negedge clk);
      c++;
    end
    check("window_period", c, 9 * nf + 2);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic run_window(input int h, input int v, input int act);
    accept_window(h, v, act);
    finish_window(clamp_nf(act), 1);
  endtask

  // Monitor: pops one expected row per valid output row.
  initial begin : monitor
    exp_t e;
    logic [AW-1:0] prev_addr;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_in) begin
        if (row_valid_out) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_row: got row %0d filter %0d expected none", row_num_out, filter_out);
          end else begin
            e = sb.pop_front();
            check("rom_addr", prev_addr, e.addr);
            check("weight_row", weight_row_out, e.data);
            check("row_num", row_num_out, e.row);
            check("filter", filter_out, e.filt);
            check("window_done", window_done_out, e.done);
            check("hcount", hcount_out, e.h);
            check("vcount", vcount_out, e.v);
          end
        end else begin
          check("done_when_idle", window_done_out, 0);
          check("weight_when_idle", weight_row_out, 0);
        end
      end
      prev_addr = rom_addr_out;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int last;
    int n;
    int cyc;
    int t;
    rst_in            = 1'b1;
    window_valid_in   = 1'b0;
    hcount_in         = '0;
    vcount_in         = '0;
    active_filters_in = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_ready", ready_out, 1);
    check("rst_row_valid", row_valid_out, 0);
    check("rst_done", window_done_out, 0);
    check("rst_addr", rom_addr_out, 0);
    check("rst_hcount", hcount_out, 0);
    check("rst_vcount", vcount_out, 0);
    check("rst_weight", weight_row_out, 0);
    #2 rst_in = 1'b0;
    @(negedge clk);

    // Full sweep, then clamping both ways.
    run_window(5, 7, 4);
    run_window(9, 1, 0);
    run_window(30, 12, 7);

    // Back-to-back with valid held and coordinates changing every cycle.
    active_filters_in = 3'd2;
    window_valid_in   = 1'b1;
    last = -1;
    n    = 0;
    cyc  = 0;
    while (n < 3 && cyc < 200) begin
      hcount_in = 5'(cyc + 3);
      vcount_in = 5'(31 - cyc);
      if (ready_out) begin
        push_window(cyc + 3, 31 - cyc, 2);
        if (last >= 0) check("b2b_interval", cyc - last, 20);
        last = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    window_valid_in = 1'b0;
    check("b2b_accepts", n, 3);
    finish_window(2, 1);

    // Reset in the middle of filter 1, row 4.
    accept_window(6, 8, 4);
    t = 0;
    while (!(row_valid_out && row_num_out == 4'd4 && filter_out == 2'd1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reset_point", {row_valid_out, row_num_out, filter_out}, {1'b1, 4'd4, 2'd1});
    #2 rst_in = 1'b1;
    #1;
    check("midrst_ready", ready_out, 1);
    check("midrst_valid", row_valid_out, 0);
    check("midrst_done", window_done_out, 0);
    check("midrst_addr", rom_addr_out, 0);
    check("midrst_weight", weight_row_out, 0);
    check("midrst_hcount", hcount_out, 0);
    sb.delete();
    @(negedge clk);
    check("midrst_done_hold", window_done_out, 0);
    #2 rst_in = 1'b0;
    @(negedge clk);
    run_window(2, 3, 4);

    // Filter count changed mid-window only affects the next window.
    accept_window(4, 4, 4);
    repeat (10) @(negedge clk);
    active_filters_in = 3'd1;
    finish_window(4, 11);
    run_window(11, 22, 1);

    check("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
